// File: rtl/matmul_sequencer.sv
// Streams two 2x2 matrices into an external multiplier, then drains the four
// products C00..C11 through a valid/ready output with abort and frame counting.
module matmul_sequencer #(
  parameter int DATA_W   = 8,
  parameter int RESULT_W = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic [7:0]          frame_cnt,
  output logic                mm_reset_n,
  output logic                mm_execute,
  output logic [2:0]          mm_sel_in,
  output logic [DATA_W-1:0]   mm_input_val,
  output logic [1:0]          mm_sel_out,
  input  logic [RESULT_W-1:0] mm_result
);

  typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

  state_t              r_state;
  logic [2:0]          r_ld_cnt;
  logic [1:0]          r_sel_q;
  logic                r_out_valid;
  logic [RESULT_W-1:0] r_out_data;
  logic [7:0]          r_frame_cnt;

  logic w_load;
  logic w_out_last;

  assign w_load     = (r_state == LOAD);
  // sel_q wraps to 0 once C11 has been captured, so 0 in EMIT marks the last word.
  assign w_out_last = (r_state == EMIT) && (r_sel_q == 2'd0);

  assign in_ready     = w_load;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = w_out_last;
  assign frame_cnt    = r_frame_cnt;
  assign busy         = !w_load || (r_ld_cnt != 3'd0);
  assign mm_reset_n   = ~reset;
  // The multiplier latches whenever execute is low, so it may only drop on a real handshake.
  assign mm_execute   = !(w_load && in_valid && !abort);
  assign mm_sel_in    = r_ld_cnt;
  assign mm_input_val = in_data;
  assign mm_sel_out   = r_sel_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= LOAD;
      r_ld_cnt    <= 3'd0;
      r_sel_q     <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_frame_cnt <= 8'd0;
    end else if (abort) begin
      r_state     <= LOAD;
      r_ld_cnt    <= 3'd0;
      r_sel_q     <= 2'd0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            if (r_ld_cnt == 3'd7) begin
              r_ld_cnt <= 3'd0;
              r_state  <= CALC;
            end else begin
              r_ld_cnt <= r_ld_cnt + 3'd1;
            end
          end
        end
        CALC: begin
          r_out_data  <= mm_result;
          r_sel_q     <= 2'd1;
          r_out_valid <= 1'b1;
          r_state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (w_out_last) begin
              r_out_valid <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_state     <= LOAD;
            end else begin
              r_out_data <= mm_result;
              r_sel_q    <= r_sel_q + 2'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench: behavioural 2x2 multiplier, stream-level reference model
// compared every cycle, directed frames with literal results, then random frames.
module tb_matmul_sequencer;

  localparam int DW = 8;
  localparam int RW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_last, busy;
  logic [RW-1:0] out_data;
  logic [7:0]    frame_cnt;
  logic          mm_reset_n, mm_execute;
  logic [2:0]    mm_sel_in;
  logic [DW-1:0] mm_input_val;
  logic [1:0]    mm_sel_out;
  logic [RW-1:0] mm_result;

  int n_tests = 0;
  int n_fail  = 0;

  matmul_sequencer #(.DATA_W(DW), .RESULT_W(RW)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt),
    .mm_reset_n(mm_reset_n), .mm_execute(mm_execute), .mm_sel_in(mm_sel_in),
    .mm_input_val(mm_input_val), .mm_sel_out(mm_sel_out), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External 2x2 multiplier: element registers written while execute is low.
  int unsigned mm_regs [8];
  always @(posedge clk or negedge mm_reset_n) begin
    if (!mm_reset_n) begin
      for (int i = 0; i < 8; i++) mm_regs[i] <= 0;
    end else if (!mm_execute) begin
      mm_regs[mm_sel_in] <= int'(mm_input_val);
    end
  end

  always_comb begin
    mm_result = '0;
    case (mm_sel_out)
      2'd0: mm_result = RW'(mm_regs[0] * mm_regs[4] + mm_regs[1] * mm_regs[6]);
      2'd1: mm_result = RW'(mm_regs[0] * mm_regs[5] + mm_regs[1] * mm_regs[7]);
      2'd2: mm_result = RW'(mm_regs[2] * mm_regs[4] + mm_regs[3] * mm_regs[6]);
      2'd3: mm_result = RW'(mm_regs[2] * mm_regs[5] + mm_regs[3] * mm_regs[7]);
      default: mm_result = '0;
    endcase
  end

  // Reference model: elements collected per frame, products queued for output.
  int unsigned m_el [8];
  int unsigned m_exp [$];
  int          m_ld = 0;
  bit          m_calc = 0;
  logic [7:0]  m_fc = 8'd0;
  int          cyc = 0;
  int          last_acc = 0;
  int unsigned got [$];
  int          got_cyc [$];
  bit          got_last [$];

  always @(negedge clk) begin
    bit          e_in_ready, e_out_valid;
    int unsigned s;
    cyc++;
    check("mm_reset_n", mm_reset_n, !reset);
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      m_ld = 0; m_calc = 0; m_exp.delete(); m_fc = 8'd0;
    end else begin
      e_in_ready  = !m_calc && (m_exp.size() == 0);
      e_out_valid = !m_calc && (m_exp.size() > 0);
      check("in_ready", in_ready, e_in_ready);
      check("out_valid", out_valid, e_out_valid);
      check("out_last", out_last, e_out_valid && (m_exp.size() == 1));
      check("busy", busy, !e_in_ready || (m_ld != 0));
      check("frame_cnt", frame_cnt, m_fc);
      check("mm_execute", mm_execute, !(e_in_ready && in_valid && !abort));
      if (e_out_valid) check("out_data", out_data, m_exp[0]);
      if (e_in_ready && in_valid) begin
        check("mm_sel_in", mm_sel_in, m_ld);
        check("mm_input_val", mm_input_val, in_data);
      end
      if (abort) begin
        m_ld = 0; m_calc = 0; m_exp.delete();
      end else if (m_calc) begin
        m_calc = 0;
      end else if (e_out_valid) begin
        if (out_ready) begin
          got.push_back(out_data);
          got_cyc.push_back(cyc);
          got_last.push_back(out_last);
          void'(m_exp.pop_front());
          if (m_exp.size() == 0) m_fc = m_fc + 8'd1;
        end
      end else if (in_valid) begin
        m_el[m_ld] = int'(in_data);
        m_ld++;
        if (m_ld == 8) begin
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
              s = 0;
              for (int k = 0; k < 2; k++) s += m_el[i*2+k] * m_el[4+k*2+j];
              m_exp.push_back(s);
            end
          m_ld = 0;
          m_calc = 1;
          last_acc = cyc;
        end
      end
    end
  end

  // out_ready pattern: 0 = held high, 1 = toggling, 2 = random.
  int rmode = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic load_frame(input int unsigned e [8], input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    bit gap = 0;
    while (i < n && guard < 200) begin
      @(posedge clk); #1;
      if (gaps && gap) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = DW'(e[i]);
      end
      gap = gaps ? !gap : 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) i++;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("load_accepted", i, n);
  endtask

  task automatic wait_outputs(input int n);
    int g = 0;
    while (got.size() < n && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    check("outputs_arrived", got.size(), n);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((m_calc || m_exp.size() != 0 || m_ld != 0) && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    check("drained", g < 300, 1);
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic check_frame(input string name, input int base, input int unsigned c0,
                             input int unsigned c1, input int unsigned c2, input int unsigned c3);
    int unsigned want [4];
    want = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      if (got.size() > base + k) check(name, got[base+k], want[k]);
      else check(name, 32'hFFFF_FFFF, want[k]);
    end
  endtask

  int unsigned f1  [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int unsigned f2  [8] = '{2, 0, 0, 2, 1, 1, 1, 1};
  int unsigned fmx [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
  int unsigned fr  [8];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d outputs", got.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d;
    #23;
    check("init_in_ready", in_ready, 1);
    check("init_busy", busy, 0);
    check("init_mm_reset_n", mm_reset_n, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic frame, out_ready high: values, latency, last flag.
    rmode = 0;
    base = got.size();
    load_frame(f1, 8, 0);
    wait_outputs(base + 4);
    check_frame("basic", base, 19, 22, 43, 50);
    if (got_cyc.size() >= base + 4) begin
      check("lat_c00", got_cyc[base] - last_acc, 2);
      check("lat_c11", got_cyc[base+3] - last_acc, 5);
      check("last_on_c00", got_last[base], 0);
      check("last_on_c11", got_last[base+3], 1);
    end else check("lat_records", got_cyc.size(), base + 4);
    repeat (2) @(negedge clk);
    check("basic_frame_cnt", frame_cnt, 1);

    // Maximum operands.
    base = got.size();
    load_frame(fmx, 8, 0);
    wait_outputs(base + 4);
    check_frame("max", base, 130050, 130050, 130050, 130050);
    repeat (2) @(negedge clk);
    check("max_frame_cnt", frame_cnt, 2);

    // Output back-pressure: no duplicates, same order.
    rmode = 1;
    base = got.size();
    load_frame(f1, 8, 0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("stall_count", got.size(), base + 4);
    check_frame("stall", base, 19, 22, 43, 50);
    check("stall_frame_cnt", frame_cnt, 3);

    // Input gaps every other cycle.
    rmode = 0;
    base = got.size();
    load_frame(f1, 8, 1);
    wait_outputs(base + 4);
    check_frame("gaps", base, 19, 22, 43, 50);
    repeat (2) @(negedge clk);
    check("gaps_frame_cnt", frame_cnt, 4);

    // Abort after five elements, then a fresh frame.
    base = got.size();
    load_frame(f1, 5, 0);
    pulse_abort();
    @(negedge clk);
    check("abort_busy", busy, 0);
    load_frame(f2, 8, 0);
    wait_outputs(base + 4);
    check_frame("abort", base, 2, 2, 2, 2);
    repeat (2) @(negedge clk);
    check("abort_frame_cnt", frame_cnt, 5);

    // Reset while emitting, right after C01 was taken.
    base = got.size();
    load_frame(f1, 8, 0);
    wait_outputs(base + 2);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = got.size();
    load_frame(f1, 8, 0);
    wait_outputs(base + 4);
    check_frame("after_rst", base, 19, 22, 43, 50);
    repeat (2) @(negedge clk);
    check("after_rst_frame_cnt", frame_cnt, 1);

    // Random frames with random gaps, back-pressure and aborts.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 8; i++) fr[i] = $urandom_range(0, 255);
      rmode = $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) begin
        load_frame(fr, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
        pulse_abort();
      end else begin
        load_frame(fr, 8, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          d = $urandom_range(0, 6);
          repeat (d) @(posedge clk);
          pulse_abort();
        end
      end
      wait_idle();
    end
    rmode = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
